decode_instruction_queue: RTL
=============================

Name: decode_instruction_queue

Overview:
- Elastic FIFO between instruction fetch and the format-specific decoders (A/B/D/... FormatDecoder).
- Accepts one fetched instruction per cycle and assigns its major ID.
- Extracts the primary opcode and presents one instruction per cycle to the decoders with an enable pulse.
- Absorbs decoder stalls and back-pressures fetch with full_o.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, fixed POWER instruction size
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- PrimOpcodeSize, 6, primary opcode width (instruction bits [0:5])
- queueDepth, 4, entries; must be a power of two
- queueIndexWidth, 2, log2(queueDepth)

Ports:
- clock_i  in  1  single clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous queue flush (branch mispredict / redirect)
- enable_i  in  1  fetch presents a valid instruction
- instruction_i  in  instructionWidth  instruction word, big-endian bit order [0:31]
- instructionAddress_i  in  addressWidth  fetch address
- is64Bit_i  in  1  64-bit mode flag
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- full_o  out  1  queue full; fetch must hold
- overflow_o  out  1  sticky: enable_i was asserted while full
- stall_i  in  1  decoders cannot accept this cycle
- enable_o  out  1  output instruction valid (single-cycle pulse per instruction)
- instructionOpcode_o  out  PrimOpcodeSize  instruction[0:5]
- instruction_o  out  instructionWidth  instruction word
- instructionAddress_o  out  addressWidth  address
- is64Bit_o  out  1  mode flag
- instructionPid_o  out  PidSize  PID
- instructionTid_o  out  TidSize  TID
- instructionMajId_o  out  instructionCounterWidth  assigned major ID
- count_o  out  queueIndexWidth+1  occupancy, 0..queueDepth

Behaviour:
- Reset (reset_i=0, async):
  - head, tail, count, major ID counter and overflow_o cleared to 0.
  - All output registers cleared to 0, including enable_o=0.
  - full_o=0.
  - A reset mid-operation discards all entries immediately.
- full_o = (count == queueDepth), combinational from count.
- Push:
  - Occurs on an edge with enable_i=1 and full_o=0.
  - Writes {instruction, address, is64Bit, pid, tid, majId=counter} at tail; tail++ with wrap modulo queueDepth.
  - Major ID counter increments by 1 and wraps 2^64-1 -> 0.
  - Push is blocked whenever full_o=1, even if a pop occurs the same cycle.
- Push while full:
  - Entry is dropped, counter not incremented, overflow_o set.
  - overflow_o clears only on reset.
- Pop:
  - Occurs on an edge with stall_i=0 and count>0.
  - Head entry is loaded into the output registers, enable_o=1, head++ with wrap.
- No pop (stall_i=1 or empty):
  - enable_o=0 after the edge.
  - Other output registers hold their previous values.
- Simultaneous push and pop: both occur and count is unchanged.
- Latency:
  - An instruction pushed into an empty queue at edge N is popped at edge N+1; enable_o is high in cycle N+1..N+2.
  - Minimum 2 edges from enable_i to enable_o.
  - Throughput is 1 instruction/cycle when unstalled.
- Ordering: strict FIFO, so output major IDs are strictly consecutive (mod 2^64).
- Flush (flush_i=1 at an edge):
  - head=tail=count=0 and enable_o=0.
  - Flush overrides push and pop in the same cycle: the concurrent input is not accepted and the counter is not incremented.
  - The major ID counter is NOT reset, so IDs stay unique across flushes.
- stall_i has no effect on push; fetch may continue filling until full_o.

Decomposition:
- Shared package (decode_pkg):
  - width constants (addressWidth, PidSize, TidSize, instructionCounterWidth, PrimOpcodeSize);
  - functional unit IDs;
  - the queue-entry packed struct {instruction, address, is64Bit, pid, tid, majId}.
- One sub-module, sync_fifo_ptrs:
  - parameterised head/tail/count pointer logic with wrap, flush and full/empty;
  - storage array and output registers stay in the top level.

Test Plan:
- Reset then single push of instruction 32'h7C0802A6, address 0x100, stall_i=0 -> enable_o pulses one cycle 2 edges later; instructionOpcode_o=6'b011111, instructionMajId_o=0, address_o=0x100; count_o returns to 0.
- stall_i=1, push 5 consecutive instructions (opcodes 0..4) -> full_o=1 after 4th, count_o=4, 5th dropped, overflow_o=1, enable_o stays 0; release stall -> 4 consecutive enable_o pulses with majId 0,1,2,3 and opcodes 0..3.
- Continuous push every cycle with stall_i=0 for 20 cycles -> count_o never exceeds 1, enable_o high every cycle after latency, majIds 0..19 in order, tail/head wrap verified.
- Fill 3 entries, assert flush_i with enable_i=1 same edge -> count_o=0, enable_o=0; next push gets majId=3 (not 0, not 4).
- Preload counter near wrap (push 2^n via forced init or long run in sim with instructionCounterWidth=4) -> majId sequence ...14,15,0,1.
- Assert reset_i low asynchronously between edges while 2 entries queued and enable_o=1 -> all outputs 0 immediately, count_o=0, overflow_o=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, functional unit IDs and the queue entry layout
package decode_pkg;
  localparam int addressWidth = 64;
  localparam int instructionWidth = 32;
  localparam int PidSize = 20;
  localparam int TidSize = 16;
  localparam int instructionCounterWidth = 64;
  localparam int PrimOpcodeSize = 6;
  typedef enum logic [3:0] {
    FU_NONE, FU_ALU, FU_LSU, FU_BRANCH, FU_FPU, FU_VECTOR, FU_SYSTEM
  } functionalUnit_t;
  // instruction keeps POWER bit numbering: bit 0 is the most significant
  typedef struct packed {
    logic [0:instructionWidth-1]        instruction;
    logic [addressWidth-1:0]            address;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] majId;
  } queueEntry_t;
  function automatic logic [PrimOpcodeSize-1:0] primOpcode(input logic [0:instructionWidth-1] instr);
    return instr[0:PrimOpcodeSize-1];
  endfunction
endpackage

// File: rtl/decode_instruction_queue_if.sv
// decode_instruction_queue_if: fetch-side and decoder-side signals of the instruction queue
interface decode_instruction_queue_if #(
  parameter int instructionCounterWidth = decode_pkg::instructionCounterWidth,
  parameter int queueIndexWidth = 2
);
  logic                                          flush_i;
  logic                                          enable_i;
  logic [0:decode_pkg::instructionWidth-1]       instruction_i;
  logic [decode_pkg::addressWidth-1:0]           instructionAddress_i;
  logic                                          is64Bit_i;
  logic [decode_pkg::PidSize-1:0]                instructionPid_i;
  logic [decode_pkg::TidSize-1:0]                instructionTid_i;
  logic                                          full_o;
  logic                                          overflow_o;
  logic                                          stall_i;
  logic                                          enable_o;
  logic [decode_pkg::PrimOpcodeSize-1:0]         instructionOpcode_o;
  logic [0:decode_pkg::instructionWidth-1]       instruction_o;
  logic [decode_pkg::addressWidth-1:0]           instructionAddress_o;
  logic                                          is64Bit_o;
  logic [decode_pkg::PidSize-1:0]                instructionPid_o;
  logic [decode_pkg::TidSize-1:0]                instructionTid_o;
  logic [instructionCounterWidth-1:0]            instructionMajId_o;
  logic [queueIndexWidth:0]                      count_o;
  modport master (
    output flush_i, enable_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, stall_i,
    input  full_o, overflow_o, enable_o, instructionOpcode_o, instruction_o,
           instructionAddress_o, is64Bit_o, instructionPid_o, instructionTid_o,
           instructionMajId_o, count_o
  );
  modport slave (
    input  flush_i, enable_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, stall_i,
    output full_o, overflow_o, enable_o, instructionOpcode_o, instruction_o,
           instructionAddress_o, is64Bit_o, instructionPid_o, instructionTid_o,
           instructionMajId_o, count_o
  );
endinterface

// File: rtl/sync_fifo_ptrs.sv
// sync_fifo_ptrs: head/tail/occupancy tracking for a power-of-two ring buffer with flush
module sync_fifo_ptrs #(
  parameter int depth = 4,
  parameter int indexWidth = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  flush,
  input  logic                  pushReq,
  input  logic                  popReq,
  output logic                  pushEn,
  output logic                  popEn,
  output logic [indexWidth-1:0] head,
  output logic [indexWidth-1:0] tail,
  output logic [indexWidth:0]   count,
  output logic                  full
);
  logic empty;
  assign full = count == (indexWidth + 1)'(depth);
  assign empty = count == '0;
  // push is judged against the pre-pop occupancy, so a full queue refuses even when draining
  assign pushEn = pushReq && !full && !flush;
  assign popEn = popReq && !empty && !flush;
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + indexWidth'(popEn);
      tail <= tail + indexWidth'(pushEn);
      count <= count + (indexWidth + 1)'(pushEn) - (indexWidth + 1)'(popEn);
    end
endmodule

// File: rtl/decode_instruction_queue.sv
// decode_instruction_queue: elastic FIFO between fetch and the format decoders, assigns major IDs
module decode_instruction_queue
  import decode_pkg::queueEntry_t, decode_pkg::primOpcode;
#(
  parameter int queueDepth = 4,
  parameter int queueIndexWidth = 2,
  parameter int instructionCounterWidth = decode_pkg::instructionCounterWidth
) (
  input logic                     clock_i,
  input logic                     reset_i,
  decode_instruction_queue_if.slave bus
);
  queueEntry_t mem [queueDepth];
  queueEntry_t outEntry;
  logic [queueIndexWidth-1:0] head, tail;
  logic [instructionCounterWidth-1:0] majId;
  logic pushEn, popEn, outValid, overflow;
  sync_fifo_ptrs #(.depth(queueDepth), .indexWidth(queueIndexWidth)) ptrs (
    .clock(clock_i),
    .resetN(reset_i),
    .flush(bus.flush_i),
    .pushReq(bus.enable_i),
    .popReq(!bus.stall_i),
    .pushEn(pushEn),
    .popEn(popEn),
    .head(head),
    .tail(tail),
    .count(bus.count_o),
    .full(bus.full_o)
  );
  always_ff @(posedge clock_i)
    if (pushEn) mem[tail] <= '{
      instruction: bus.instruction_i,
      address: bus.instructionAddress_i,
      is64Bit: bus.is64Bit_i,
      pid: bus.instructionPid_i,
      tid: bus.instructionTid_i,
      majId: decode_pkg::instructionCounterWidth'(majId)
    };
  // major ID survives flushes so IDs stay unique across redirects
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      majId <= '0;
      overflow <= 1'b0;
      outValid <= 1'b0;
      outEntry <= '0;
    end else begin
      if (pushEn) majId <= majId + instructionCounterWidth'(1);
      if (bus.enable_i && bus.full_o && !bus.flush_i) overflow <= 1'b1;
      outValid <= popEn;
      if (popEn) outEntry <= mem[head];
    end
  assign bus.overflow_o = overflow;
  assign bus.enable_o = outValid;
  assign bus.instructionOpcode_o = primOpcode(outEntry.instruction);
  assign bus.instruction_o = outEntry.instruction;
  assign bus.instructionAddress_o = outEntry.address;
  assign bus.is64Bit_o = outEntry.is64Bit;
  assign bus.instructionPid_o = outEntry.pid;
  assign bus.instructionTid_o = outEntry.tid;
  assign bus.instructionMajId_o = outEntry.majId[instructionCounterWidth-1:0];
endmodule
